// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between mem_port_arbiter, the core's fetch / load-store ports and the data memory.
// The slave modport is the arbiter's view; master is the core-plus-memory side.
interface mem_port_arbiter_if #(
  parameter int AW = 24,
  parameter int DW = 24
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic [DW-1:0] ls_rdata;
  logic          ls_ack;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata,
    input  mem_rdata,
    output if_rdata, if_ack,
    output ls_rdata, ls_ack,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata,
    output mem_rdata,
    input  if_rdata, if_ack,
    input  ls_rdata, ls_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store requests onto the single-ported data memory, one access per 4 cycles.
// Define ARB_ROUND_ROBIN_EN to alternate grants on a tie; otherwise load/store always beats fetch.
module mem_port_arbiter #(
  parameter int AW = 24,
  parameter int DW = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t        state, state_nxt;

  // Transaction context latched at grant time; request inputs are ignored afterwards.
  logic          gnt_ls, gnt_ls_nxt;
  logic          op_we, op_we_nxt;

  logic [AW-1:0] mem_addr_q, mem_addr_nxt;
  logic [DW-1:0] mem_wdata_q, mem_wdata_nxt;
  logic          mem_we_q, mem_we_nxt;
  logic          mem_re_q, mem_re_nxt;
  logic [DW-1:0] if_rdata_q, if_rdata_nxt;
  logic [DW-1:0] ls_rdata_q, ls_rdata_nxt;
  logic          if_ack_q, if_ack_nxt;
  logic          ls_ack_q, ls_ack_nxt;
  logic          busy_q, busy_nxt;

  logic          sel_ls;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers which port won last; resets to fetch so the first tie goes to load/store.
  logic          last_ls;

  always_comb begin
    if (bus.ls_req && bus.if_req) begin
      sel_ls = ~last_ls;
    end else begin
      sel_ls = bus.ls_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ls <= 1'b0;
    end else if (state == IDLE && (bus.ls_req || bus.if_req)) begin
      last_ls <= sel_ls;
    end
  end
`else
  always_comb begin
    sel_ls = bus.ls_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_ls      <= 1'b0;
      op_we       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state       <= state_nxt;
      gnt_ls      <= gnt_ls_nxt;
      op_we       <= op_we_nxt;
      mem_addr_q  <= mem_addr_nxt;
      mem_wdata_q <= mem_wdata_nxt;
      mem_we_q    <= mem_we_nxt;
      mem_re_q    <= mem_re_nxt;
      if_rdata_q  <= if_rdata_nxt;
      ls_rdata_q  <= ls_rdata_nxt;
      if_ack_q    <= if_ack_nxt;
      ls_ack_q    <= ls_ack_nxt;
      busy_q      <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    gnt_ls_nxt    = gnt_ls;
    op_we_nxt     = op_we;
    mem_addr_nxt  = mem_addr_q;
    mem_wdata_nxt = mem_wdata_q;
    mem_we_nxt    = 1'b0;
    mem_re_nxt    = 1'b0;
    if_rdata_nxt  = if_rdata_q;
    ls_rdata_nxt  = ls_rdata_q;
    if_ack_nxt    = 1'b0;
    ls_ack_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.ls_req || bus.if_req) begin
          gnt_ls_nxt = sel_ls;
          // The fetch port is read-only, so only a load/store grant can write.
          op_we_nxt  = sel_ls & bus.ls_we;
          if (sel_ls) begin
            mem_addr_nxt  = bus.ls_addr;
            mem_wdata_nxt = bus.ls_wdata;
          end else begin
            mem_addr_nxt  = bus.if_addr;
          end
          mem_we_nxt = op_we_nxt;
          mem_re_nxt = ~op_we_nxt;
          state_nxt  = ACCESS;
        end
      end
      ACCESS: begin
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        // Memory read data is valid in this cycle; stores leave the port's rdata untouched.
        if (!op_we) begin
          if (gnt_ls) begin
            ls_rdata_nxt = bus.mem_rdata;
          end else begin
            if_rdata_nxt = bus.mem_rdata;
          end
        end
        if (gnt_ls) begin
          ls_ack_nxt = 1'b1;
        end else begin
          if_ack_nxt = 1'b1;
        end
        state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_re    = mem_re_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.busy      = busy_q;

endmodule
